load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Responder for the LSU request that Decode issues (en_lsu / lsu_operator / ALU address / store data).
//  Turns each request into one data-bus transaction and returns sign/zero-extended load data.
//  Decode uses mem_data_valid_op as its register-file writeback strobe.
//  Sits between Decode/ALU and the data memory port; one transaction is outstanding at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT_RVALID before bus_error_op; 0 = no timeout
// PORTS
//  clock            in   1   core clock
//  reset            in   1   synchronous, active-high
//  en_lsu_ip        in   1   request strobe from Decode
//  lsu_operator_ip  in   load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW (CORE_PKG)
//  addr_ip          in   32  effective address (ALU result)
//  addr_valid_ip    in   1   ALU result valid
//  wdata_ip         in   32  store data (rs2)
//  mem_data_op      out  32  extended load data to writeback mux
//  mem_data_valid_op out 1   1-cycle pulse, loads only
//  done_op          out  1   1-cycle pulse at completion of any load or store
//  busy_op          out  1   high whenever state != IDLE
//  misaligned_op    out  1   1-cycle pulse, request rejected
//  bus_error_op     out  1   1-cycle pulse on timeout
//  data_req_op      out  1   bus request
//  data_gnt_ip      in   1   bus grant
//  data_addr_op     out  32  word-aligned address ({addr[31:2],2'b00})
//  data_we_op       out  1   1 = store
//  data_be_op       out  4   byte enables
//  data_wdata_op    out  32  lane-replicated store data
//  data_rvalid_ip   in   1   read data valid / write ack
//  data_rdata_ip    in   32  read data
// BEHAVIOUR
//  - Reset: state=IDLE, timeout counter=0, all outputs 0.
//  - Reset mid-transaction abandons it. rvalid/gnt arriving after reset are ignored.
//  - FSM IDLE->REQ->WAIT_RVALID->IDLE.
//  - IDLE: a request is accepted when en_lsu_ip && addr_valid_ip.
//  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//    Pulses misaligned_op next cycle, stays IDLE, no bus activity.
//  - Otherwise op, addr[1:0] and bus fields are registered, and the FSM goes to REQ.
//  - REQ: data_req_op=1.
//    addr/we/be/wdata are held stable until the cycle data_gnt_ip=1, then WAIT_RVALID; req drops.
//  - WAIT_RVALID: counter increments each cycle.
//    On data_rvalid_ip: done_op=1 next cycle.
//    For loads, mem_data_valid_op=1 and mem_data_op registered the same cycle. Then IDLE.
//  - Timeout: counter reaches TIMEOUT_CYCLES without rvalid -> bus_error_op pulse, IDLE, no data valid.
//  - Requests while busy_op=1 are ignored; Decode must stall.
//    rvalid in IDLE/REQ is ignored.
//  - mem_data_op holds its last value between pulses.
//  - Latency: accept in cycle N, req in N+1, gnt in N+1, rvalid in N+2 -> mem_data_valid_op in N+3.
//  - Byte enables:
//    B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111. Loads drive be too.
//  - Store data:
//    SB: {4{wdata[7:0]}}; SH: {2{wdata[15:0]}}; SW: wdata.
//  - Load extract:
//    lane = rdata >> (8*addr[1:0]).
//    LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unmodified.
// TESTING
//  1. LW 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF
//     -> mem_data_op=0xDEADBEEF, valid pulse at N+3, done_op pulse.
//  2. LB 0x103, rdata 0x80FF0000 -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
//  3. SH 0x202 wdata 0x1234ABCD, gnt delayed 3 cycles
//     -> addr 0x200, be 4'b1100, wdata 0xABCDABCD, we=1, stable until gnt.
//     -> done_op pulses, mem_data_valid_op never.
//  4. LW 0x101 -> misaligned_op pulse, data_req_op never asserted, busy_op stays 0.
//  5. TIMEOUT_CYCLES=16, no rvalid -> bus_error_op after 16 WAIT cycles, IDLE, no data valid.
//  6. Reset in WAIT_RVALID, then stray rvalid -> no valid/done pulse; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-bus load/store responder with extended load return
package core_pkg;
  typedef enum logic [2:0] {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW} load_store_func_code;
endpackage

module load_store_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en_lsu_ip,
  input  load_store_func_code lsu_operator_ip,
  input  logic [31:0]         addr_ip,
  input  logic                addr_valid_ip,
  input  logic [31:0]         wdata_ip,
  output logic [31:0]         mem_data_op,
  output logic                mem_data_valid_op,
  output logic                done_op,
  output logic                busy_op,
  output logic                misaligned_op,
  output logic                bus_error_op,
  output logic                data_req_op,
  input  logic                data_gnt_ip,
  output logic [31:0]         data_addr_op,
  output logic                data_we_op,
  output logic [3:0]          data_be_op,
  output logic [31:0]         data_wdata_op,
  input  logic                data_rvalid_ip,
  input  logic [31:0]         data_rdata_ip
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  load_store_func_code op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                mis_q, mis_d;
  logic                err_q, err_d;

  logic        is_b, is_h, is_st, misaligned, timed_out;
  logic [3:0]  be_req;
  logic [31:0] wdata_req, lane, load_ext;

  assign is_b       = lsu_operator_ip inside {LSU_LB, LSU_LBU, LSU_SB};
  assign is_h       = lsu_operator_ip inside {LSU_LH, LSU_LHU, LSU_SH};
  assign is_st      = lsu_operator_ip inside {LSU_SB, LSU_SH, LSU_SW};
  assign misaligned = is_h ? addr_ip[0] : (!is_b && addr_ip[1:0] != 2'b00);
  assign be_req     = is_b ? 4'b0001 << addr_ip[1:0] : is_h ? 4'b0011 << addr_ip[1:0] : 4'b1111;
  assign wdata_req  = is_b ? {4{wdata_ip[7:0]}} : is_h ? {2{wdata_ip[15:0]}} : wdata_ip;
  assign lane       = data_rdata_ip >> {off_q, 3'b000};
  assign load_ext   = op_q == LSU_LB  ? {{24{lane[7]}}, lane[7:0]} :
                      op_q == LSU_LBU ? {24'b0, lane[7:0]} :
                      op_q == LSU_LH  ? {{16{lane[15]}}, lane[15:0]} :
                      op_q == LSU_LHU ? {16'b0, lane[15:0]} : lane;
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign mem_data_op       = rdata_q;
  assign mem_data_valid_op = valid_q;
  assign done_op           = done_q;
  assign misaligned_op     = mis_q;
  assign bus_error_op      = err_q;
  assign busy_op           = state_q != IDLE;
  assign data_req_op       = state_q == REQ;
  assign data_addr_op      = addr_q;
  assign data_we_op        = we_q;
  assign data_be_op        = be_q;
  assign data_wdata_op     = wdata_q;

  // Next-state logic: accept/reject in IDLE, hold bus fields through REQ, complete or time out in WAIT_RVALID
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (en_lsu_ip && addr_valid_ip) begin
        if (misaligned) mis_d = 1'b1;
        else begin
          state_d = REQ;
          op_d    = lsu_operator_ip;
          off_d   = addr_ip[1:0];
          addr_d  = {addr_ip[31:2], 2'b00};
          we_d    = is_st;
          be_d    = be_req;
          wdata_d = wdata_req;
        end
      end
      REQ: if (data_gnt_ip) begin
        state_d = WAIT_RVALID;
        cnt_d   = '0;
      end
      WAIT_RVALID: if (data_rvalid_ip) begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!(op_q inside {LSU_SB, LSU_SH, LSU_SW})) begin
          valid_d = 1'b1;
          rdata_d = load_ext;
        end
      end else if (timed_out) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= LSU_LB;
      off_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level model
module tb_load_store_unit;
  import core_pkg::*;
  localparam int TO = 16;

  logic clock = 0, reset = 1, en = 0, addr_valid = 0, gnt = 0, rvalid = 0;
  load_store_func_code op = LSU_LW;
  logic [31:0] addr = 0, wdata = 0, rdata = 0;
  logic [31:0] mem_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        mem_valid, done, busy, mis, err, req, we;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .en_lsu_ip(en), .lsu_operator_ip(op), .addr_ip(addr),
    .addr_valid_ip(addr_valid), .wdata_ip(wdata), .mem_data_op(mem_data), .mem_data_valid_op(mem_valid),
    .done_op(done), .busy_op(busy), .misaligned_op(mis), .bus_error_op(err), .data_req_op(req),
    .data_gnt_ip(gnt), .data_addr_op(bus_addr), .data_we_op(we), .data_be_op(bus_be),
    .data_wdata_op(bus_wdata), .data_rvalid_ip(rvalid), .data_rdata_ip(rdata)
  );

  always #5 clock = ~clock;

  int checks = 0, fails = 0;

  int          valid_cyc, done_cyc, err_cyc, mis_cyc, valid_cnt, done_cnt, err_cnt, mis_cnt;
  bit          req_seen, stable, busy_seen;
  logic [31:0] o_data, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int size_of(load_store_func_code o);
    return (o inside {LSU_LB, LSU_LBU, LSU_SB}) ? 1 : (o inside {LSU_LH, LSU_LHU, LSU_SH}) ? 2 : 4;
  endfunction

  function automatic bit is_store(load_store_func_code o);
    return o inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic bit m_misaligned(load_store_func_code o, logic [31:0] a);
    return (a % size_of(o)) != 0;
  endfunction

  function automatic logic [3:0] m_be(load_store_func_code o, logic [31:0] a);
    int s = size_of(o);
    return 4'(((1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(load_store_func_code o, logic [31:0] d);
    logic [31:0] r;
    int s = size_of(o);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(load_store_func_code o, logic [31:0] a, logic [31:0] rd);
    int s = size_of(o);
    longint v = (longint'(rd) >> (8 * (a % 4))) % (longint'(1) << (8 * s));
    if ((o == LSU_LB || o == LSU_LH) && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
    return 32'(v);
  endfunction

  // Issue one request and act as the memory: grant after g req cycles, rvalid after r wait cycles (r<0: never)
  task automatic run_txn(input load_store_func_code o, input logic [31:0] a, input logic [31:0] wd,
                         input int g, input int r, input logic [31:0] rd, input int max_cyc);
    int gc = 0, wc = 0;
    bit granted = 0, rv_done = 0;
    valid_cyc = -1; done_cyc = -1; err_cyc = -1; mis_cyc = -1;
    valid_cnt = 0; done_cnt = 0; err_cnt = 0; mis_cnt = 0;
    req_seen = 0; stable = 1; busy_seen = 0;
    op = o; addr = a; wdata = wd; en = 1; addr_valid = 1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      en = 0; addr_valid = 0; gnt = 0; rvalid = 0; rdata = $urandom;
      if (busy) busy_seen = 1;
      if (mem_valid) begin valid_cnt++; if (valid_cyc < 0) valid_cyc = c; o_data = mem_data; end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (err) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
      if (mis) begin mis_cnt++; if (mis_cyc < 0) mis_cyc = c; end
      if (req) begin
        if (!req_seen) begin o_addr = bus_addr; o_be = bus_be; o_we = we; o_wdata = bus_wdata; end
        else if (o_addr !== bus_addr || o_be !== bus_be || o_we !== we || o_wdata !== bus_wdata) stable = 0;
        req_seen = 1;
        if (gc == g) begin gnt = 1; granted = 1; end else gc++;
      end else if (granted && !rv_done) begin
        if (r >= 0 && wc == r) begin rvalid = 1; rdata = rd; rv_done = 1; end else wc++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1;
    rvalid = 1; gnt = 1;
    repeat (3) tick();
    rvalid = 0; gnt = 0;
    checks++; if ({mem_valid, done, busy, mis, err, req, we} !== 7'b0) begin fails++; $display("FAIL reset_flags got %b want 0000000", {mem_valid, done, busy, mis, err, req, we}); end
    checks++; if (mem_data !== 32'h0) begin fails++; $display("FAIL reset_mem_data got %h want 00000000", mem_data); end
    checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin fails++; $display("FAIL reset_bus got %h/%b/%h want 0", bus_addr, bus_be, bus_wdata); end
    reset = 0;
    tick();
  endtask

  task automatic test_lw;
    run_txn(LSU_LW, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 8);
    checks++; if (valid_cyc !== 3 || valid_cnt !== 1) begin fails++; $display("FAIL lw_valid_timing got cyc=%0d cnt=%0d want cyc=3 cnt=1", valid_cyc, valid_cnt); end
    checks++; if (o_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h want deadbeef", o_data); end
    checks++; if (done_cyc !== 3 || done_cnt !== 1) begin fails++; $display("FAIL lw_done got cyc=%0d cnt=%0d want cyc=3 cnt=1", done_cyc, done_cnt); end
    checks++; if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin fails++; $display("FAIL lw_bus got %h/%b/%b want 00000100/1111/0", o_addr, o_be, o_we); end
    checks++; if (mem_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_hold got %h want deadbeef", mem_data); end
  endtask

  task automatic test_extend;
    run_txn(LSU_LB, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 8);
    checks++; if (valid_cnt !== 1 || o_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_ext got %h cnt=%0d want ffffff80", o_data, valid_cnt); end
    checks++; if (o_be !== 4'b1000 || o_addr !== 32'h100) begin fails++; $display("FAIL lb_bus got %b/%h want 1000/00000100", o_be, o_addr); end
    run_txn(LSU_LBU, 32'h103, 32'h0, 1, 2, 32'h80FF0000, 10);
    checks++; if (valid_cnt !== 1 || o_data !== 32'h00000080 || valid_cyc !== 6) begin fails++; $display("FAIL lbu_ext got %h cyc=%0d want 00000080 cyc=6", o_data, valid_cyc); end
    run_txn(LSU_LH, 32'h102, 32'h0, 0, 0, 32'h80FF0000, 8);
    checks++; if (valid_cnt !== 1 || o_data !== 32'hFFFF80FF) begin fails++; $display("FAIL lh_ext got %h want ffff80ff", o_data); end
    checks++; if (o_be !== 4'b1100) begin fails++; $display("FAIL lh_be got %b want 1100", o_be); end
  endtask

  task automatic test_store_gnt_delay;
    run_txn(LSU_SH, 32'h202, 32'h1234ABCD, 3, 0, 32'h0, 10);
    checks++; if (o_addr !== 32'h200 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_we !== 1'b1) begin fails++; $display("FAIL sh_bus got %h/%b/%h/%b want 00000200/1100/abcdabcd/1", o_addr, o_be, o_wdata, o_we); end
    checks++; if (!stable) begin fails++; $display("FAIL sh_stable got unstable want stable"); end
    checks++; if (done_cyc !== 6 || done_cnt !== 1) begin fails++; $display("FAIL sh_done got cyc=%0d cnt=%0d want cyc=6 cnt=1", done_cyc, done_cnt); end
    checks++; if (valid_cnt !== 0) begin fails++; $display("FAIL sh_no_valid got %0d want 0", valid_cnt); end
  endtask

  task automatic test_misaligned;
    run_txn(LSU_LW, 32'h101, 32'h0, 0, 0, 32'h0, 6);
    checks++; if (mis_cyc !== 1 || mis_cnt !== 1) begin fails++; $display("FAIL mis_pulse got cyc=%0d cnt=%0d want cyc=1 cnt=1", mis_cyc, mis_cnt); end
    checks++; if (req_seen || busy_seen) begin fails++; $display("FAIL mis_quiet got req=%0b busy=%0b want 0/0", req_seen, busy_seen); end
    run_txn(LSU_SH, 32'h203, 32'h0, 0, 0, 32'h0, 6);
    checks++; if (mis_cnt !== 1 || req_seen || done_cnt !== 0) begin fails++; $display("FAIL mis_sh got mis=%0d req=%0b done=%0d want 1/0/0", mis_cnt, req_seen, done_cnt); end
  endtask

  task automatic test_timeout;
    run_txn(LSU_LW, 32'h40, 32'h0, 0, -1, 32'h0, TO + 6);
    checks++; if (err_cyc !== TO + 2 || err_cnt !== 1) begin fails++; $display("FAIL timeout_err got cyc=%0d cnt=%0d want cyc=%0d cnt=1", err_cyc, err_cnt, TO + 2); end
    checks++; if (valid_cnt !== 0 || done_cnt !== 0 || busy) begin fails++; $display("FAIL timeout_idle got valid=%0d done=%0d busy=%0b want 0/0/0", valid_cnt, done_cnt, busy); end
    run_txn(LSU_LW, 32'h44, 32'h0, 0, TO - 1, 32'h0BADF00D, TO + 6);
    checks++; if (err_cnt !== 0 || valid_cnt !== 1 || o_data !== 32'h0BADF00D) begin fails++; $display("FAIL timeout_edge got err=%0d valid=%0d data=%h want 0/1/0badf00d", err_cnt, valid_cnt, o_data); end
  endtask

  task automatic test_reset_mid;
    bit bad = 0;
    op = LSU_LW; addr = 32'h300; en = 1; addr_valid = 1;
    tick();
    en = 0; addr_valid = 0; gnt = 1;
    tick();
    gnt = 0;
    checks++; if (!busy || req) begin fails++; $display("FAIL rstmid_wait got busy=%0b req=%0b want 1/0", busy, req); end
    reset = 1;
    tick();
    reset = 0; rvalid = 1; gnt = 1; rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      rvalid = 0; gnt = 0;
      if (mem_valid || done || busy || req) bad = 1;
    end
    checks++; if (bad) begin fails++; $display("FAIL rstmid_stray got activity want none"); end
    run_txn(LSU_LW, 32'h304, 32'h0, 0, 0, 32'h13579BDF, 8);
    checks++; if (valid_cyc !== 3 || o_data !== 32'h13579BDF) begin fails++; $display("FAIL rstmid_next got cyc=%0d data=%h want 3/13579bdf", valid_cyc, o_data); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      load_store_func_code o = load_store_func_code'($urandom_range(0, 7));
      logic [31:0] a = $urandom, wd = $urandom, rd = $urandom;
      int g = $urandom_range(0, 3), r = $urandom_range(0, 4);
      run_txn(o, a, wd, g, r, rd, g + r + 5);
      if (m_misaligned(o, a)) begin
        checks++; if (mis_cnt !== 1 || req_seen || done_cnt !== 0) begin fails++; $display("FAIL rnd_mis op=%0d a=%h got mis=%0d req=%0b want 1/0", o, a, mis_cnt, req_seen); end
      end else begin
        checks++; if (mis_cnt !== 0 || o_addr !== (a & 32'hFFFFFFFC) || o_be !== m_be(o, a) || o_we !== is_store(o) || !stable) begin fails++; $display("FAIL rnd_bus op=%0d a=%h got %h/%b/%b want %h/%b/%b", o, a, o_addr, o_be, o_we, a & 32'hFFFFFFFC, m_be(o, a), is_store(o)); end
        checks++; if (done_cyc !== 3 + g + r || done_cnt !== 1) begin fails++; $display("FAIL rnd_done op=%0d got cyc=%0d want %0d", o, done_cyc, 3 + g + r); end
        if (is_store(o)) begin
          checks++; if (o_wdata !== m_wdata(o, wd) || valid_cnt !== 0) begin fails++; $display("FAIL rnd_store op=%0d got %h valid=%0d want %h valid=0", o, o_wdata, valid_cnt, m_wdata(o, wd)); end
        end else begin
          checks++; if (valid_cyc !== 3 + g + r || o_data !== m_load(o, a, rd)) begin fails++; $display("FAIL rnd_load op=%0d a=%h rd=%h got %h cyc=%0d want %h cyc=%0d", o, a, rd, o_data, valid_cyc, m_load(o, a, rd), 3 + g + r); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extend();
    test_store_gnt_delay();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
